instr_exec_reader: RTL and testbench

//  Reader/executor at the far end of the instruction register: walks a programmed index range,

---
 rtl/instr_exec_reader_pkg.sv | 23 ++
 rtl/instr_exec_reader.sv | 145 ++++++++++++++
 tb/tb_instr_exec_reader.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_exec_reader_pkg.sv
// Instruction types shared with instr_register: opcode, operands and the packed instruction word.
package instr_exec_reader_pkg;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

endpackage

// File: rtl/instr_exec_reader.sv
// instr_exec_reader: walks an index range of the instruction register, executes each entry
// and offers the results one at a time on a valid/ready port.
// Optional feature: define INSTR_EXEC_DIV_EN to build the DIV/MOD datapath; without it DIV/MOD
// report div_err with a zero result.
module instr_exec_reader
  import instr_exec_reader_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                reset_en_i,
  input  logic                start_i,
  input  logic [IDX_W-1:0]    start_index_i,
  input  logic [IDX_W:0]      num_instr_i,
  output logic [IDX_W-1:0]    read_index_o,
  input  instruction_t        instruction_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic signed [63:0]  result_o,
  output logic [IDX_W-1:0]    result_index_o,
  output opcode_t             result_opc_o,
  output logic                div_err_o,
  output logic                busy_o,
  output logic                done_o
);

  typedef enum logic [2:0] {StIdle, StFetch, StExec, StOut, StDone} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W:0]     rem_q, rem_d;
  logic signed [63:0] res_q, res_d;
  logic [IDX_W-1:0]   res_idx_q, res_idx_d;
  opcode_t            opc_q, opc_d;
  logic               err_q, err_d;

  logic signed [63:0] a64, b64, alu_res;
  logic               alu_err;
  logic [IDX_W:0]     num_clamped;

  assign num_clamped = (num_instr_i > (IDX_W+1)'(DEPTH)) ? (IDX_W+1)'(DEPTH) : num_instr_i;

  // Execute the instruction currently presented by the register.
  always_comb begin
    a64     = {{32{instruction_i.op_a[31]}}, instruction_i.op_a};
    b64     = {{32{instruction_i.op_b[31]}}, instruction_i.op_b};
    alu_res = '0;
    alu_err = 1'b0;
    case (instruction_i.opc)
      ZERO:  alu_res = '0;
      PASSA: alu_res = a64;
      PASSB: alu_res = b64;
      ADD:   alu_res = a64 + b64;
      SUB:   alu_res = a64 - b64;
      MULT:  alu_res = a64 * b64;  // 32x32 signed product always fits in 64 bits
`ifdef INSTR_EXEC_DIV_EN
      DIV: begin
        if (b64 == '0) alu_err = 1'b1;
        else           alu_res = a64 / b64;
      end
      MOD: begin
        if (b64 == '0) alu_err = 1'b1;
        else           alu_res = a64 % b64;
      end
`else
      DIV:   alu_err = 1'b1;
      MOD:   alu_err = 1'b1;
`endif
      default: alu_err = 1'b1;
    endcase
  end

  // Next-state logic for the run sequencer and the result holding registers.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    res_d     = res_q;
    res_idx_d = res_idx_q;
    opc_d     = opc_q;
    err_d     = err_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          idx_d   = start_index_i;
          rem_d   = num_clamped;
          state_d = (num_clamped == '0) ? StDone : StFetch;
        end
      end
      StFetch: state_d = StExec;
      StExec: begin
        res_d     = alu_res;
        err_d     = alu_err;
        opc_d     = instruction_i.opc;
        res_idx_d = idx_q;
        state_d   = StOut;
      end
      StOut: begin
        if (result_ready_i) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == (IDX_W+1)'(1)) begin
            state_d = StDone;
          end else begin
            idx_d   = (idx_q == IDX_W'(DEPTH - 1)) ? '0 : idx_q + 1'b1;
            state_d = StFetch;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_en_i) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      rem_q     <= '0;
      res_q     <= '0;
      res_idx_q <= '0;
      opc_q     <= ZERO;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
      res_q     <= res_d;
      res_idx_q <= res_idx_d;
      opc_q     <= opc_d;
      err_q     <= err_d;
    end
  end

  assign read_index_o   = idx_q;
  assign result_valid_o = (state_q == StOut);
  assign result_o       = res_q;
  assign result_index_o = res_idx_q;
  assign result_opc_o   = opc_q;
  assign div_err_o      = err_q;
  assign busy_o         = (state_q == StFetch) || (state_q == StExec) || (state_q == StOut);
  assign done_o         = (state_q == StDone);

endmodule

// File: tb/tb_instr_exec_reader.sv
// Directed bench for instr_exec_reader: table of instructions plus hand-written sequences.
module tb_instr_exec_reader;
  import instr_exec_reader_pkg::*;

`ifdef INSTR_EXEC_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif
  localparam int N = 15;

  logic               clk = 1'b0;
  logic               reset_en = 1'b0;
  logic               start = 1'b0;
  logic [4:0]         start_index = '0;
  logic [5:0]         num_instr = '0;
  logic [4:0]         read_index;
  instruction_t       instruction;
  logic               result_valid;
  logic               result_ready = 1'b0;
  logic signed [63:0] result;
  logic [4:0]         result_index;
  opcode_t            result_opc;
  logic               div_err, busy, done;

  instruction_t mem [32];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    opcode_t            opc;
    logic signed [31:0] a;
    logic signed [31:0] b;
    logic signed [63:0] exp_res;
    logic               exp_err;
  } vec_t;
  vec_t tbl [N];

  assign instruction = mem[read_index];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_exec_reader dut (
    .clk_i          (clk),
    .reset_en_i     (reset_en),
    .start_i        (start),
    .start_index_i  (start_index),
    .num_instr_i    (num_instr),
    .read_index_o   (read_index),
    .instruction_i  (instruction),
    .result_valid_o (result_valid),
    .result_ready_i (result_ready),
    .result_o       (result),
    .result_index_o (result_index),
    .result_opc_o   (result_opc),
    .div_err_o      (div_err),
    .busy_o         (busy),
    .done_o         (done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, $signed(act), act,
               $signed(exp), exp);
    end
  endtask

  task automatic do_start(input logic [4:0] idx, input logic [5:0] num);
    @(negedge clk);
    start = 1'b1; start_index = idx; num_instr = num;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (result_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk({name, "_valid_seen"}, 64'(ok), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_cyc;
    int cnt;
    bit seen_done;
    int e;

    tbl[0]  = '{ADD,   5, 7, 12, 1'b0};
    tbl[1]  = '{SUB,   3, 10, -7, 1'b0};
    tbl[2]  = '{MULT, -4, 6, -24, 1'b0};
    tbl[3]  = '{PASSB, 1, 99, 99, 1'b0};
    tbl[4]  = '{PASSA, -5, 3, -5, 1'b0};
    tbl[5]  = '{ZERO,  8, 9, 0, 1'b0};
    tbl[6]  = '{MULT,  100000, 100000, 64'sd10000000000, 1'b0};
    tbl[7]  = '{ADD,   32'h7fff_ffff, 1, 64'sd2147483648, 1'b0};
    tbl[8]  = '{SUB,   32'h8000_0000, 1, -64'sd2147483649, 1'b0};
    tbl[9]  = '{DIV,  -7, 2, DivEn ? -3 : 0, !DivEn};
    tbl[10] = '{MOD,  -7, 2, DivEn ? -1 : 0, !DivEn};
    tbl[11] = '{DIV,   9, 0, 0, 1'b1};
    tbl[12] = '{MOD,   7, -2, DivEn ? 1 : 0, !DivEn};
    tbl[13] = '{MOD,   5, 0, 0, 1'b1};
    tbl[14] = '{opcode_t'(4'hF), 1, 1, 0, 1'b1};
    for (int i = 0; i < 32; i++) mem[i] = '{opc: ZERO, op_a: 0, op_b: 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(result_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_read_index", 64'(read_index), 0);
    chk("rst_result", result, 0);
    reset_en = 1'b1;

    // Table run with ready held high
    for (int i = 0; i < N; i++) mem[i] = '{opc: tbl[i].opc, op_a: tbl[i].a, op_b: tbl[i].b};
    result_ready = 1'b1;
    do_start(0, 6'(N));
    chk("tbl_busy", 64'(busy), 1);
    last_cyc = 0;
    for (int i = 0; i < N; i++) begin
      wait_valid($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_result", i), result, tbl[i].exp_res);
      chk($sformatf("tbl%0d_index", i), 64'(result_index), 64'(i));
      chk($sformatf("tbl%0d_opc", i), 64'(result_opc), 64'(tbl[i].opc));
      chk($sformatf("tbl%0d_err", i), 64'(div_err), 64'(tbl[i].exp_err));
      if (i > 0) chk($sformatf("tbl%0d_gap", i), 64'(cyc - last_cyc), 3);
      last_cyc = cyc;
      @(negedge clk);
    end
    chk("tbl_done", 64'(done), 1);
    chk("tbl_done_busy", 64'(busy), 0);
    chk("tbl_done_valid", 64'(result_valid), 0);
    @(negedge clk);
    chk("tbl_done_pulse", 64'(done), 0);

    // Backpressure: result held stable while ready is low
    mem[5] = '{opc: ADD, op_a: 1, op_b: 2};
    mem[6] = '{opc: SUB, op_a: 9, op_b: 4};
    result_ready = 1'b0;
    do_start(5, 2);
    wait_valid("bp0");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(result_valid), 1);
      chk("bp_hold_result", result, 3);
      chk("bp_hold_index", 64'(result_index), 5);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk("bp_one_xfer", 64'(result_valid), 0);
    wait_valid("bp1");
    chk("bp1_result", result, 5);
    chk("bp1_index", 64'(result_index), 6);
    @(negedge clk);
    chk("bp1_hold", 64'(result_valid), 1);
    result_ready = 1'b1;
    @(negedge clk);
    chk("bp_done", 64'(done), 1);

    // Index wrap: 30,31,0,1
    mem[30] = '{opc: PASSA, op_a: 300, op_b: 0};
    mem[31] = '{opc: PASSA, op_a: 310, op_b: 0};
    mem[0]  = '{opc: PASSA, op_a: 0,   op_b: 0};
    mem[1]  = '{opc: PASSA, op_a: 10,  op_b: 0};
    do_start(30, 4);
    for (int k = 0; k < 4; k++) begin
      e = (30 + k) % 32;
      wait_valid("wrap");
      chk("wrap_read_index", 64'(read_index), 64'(e));
      chk("wrap_result_index", 64'(result_index), 64'(e));
      chk("wrap_result", result, 64'(e * 10));
      @(negedge clk);
    end
    chk("wrap_done", 64'(done), 1);

    // Zero-length run
    @(negedge clk);
    do_start(3, 0);
    chk("zero_done", 64'(done), 1);
    chk("zero_busy", 64'(busy), 0);
    chk("zero_valid", 64'(result_valid), 0);
    @(negedge clk);
    chk("zero_done_pulse", 64'(done), 0);

    // Oversized count clamps to a full pass over the register
    do_start(0, 63);
    cnt = 0; seen_done = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (result_valid) cnt++;
      if (done) begin seen_done = 1'b1; break; end
      @(negedge clk);
    end
    chk("clamp_count", 64'(cnt), 32);
    chk("clamp_done", 64'(seen_done), 1);

    // Start while busy is ignored
    @(negedge clk);
    mem[0] = '{opc: ADD, op_a: 1, op_b: 1};
    mem[1] = '{opc: ADD, op_a: 2, op_b: 2};
    do_start(0, 2);
    start = 1'b1; start_index = 10; num_instr = 5;
    @(negedge clk);
    start = 1'b0;
    cnt = 0; seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (result_valid) begin
        chk("busy_start_index", 64'(result_index), 64'(cnt));
        chk("busy_start_result", result, 64'(2 * (cnt + 1)));
        cnt++;
      end
      if (done) begin seen_done = 1'b1; break; end
      @(negedge clk);
    end
    chk("busy_start_count", 64'(cnt), 2);
    chk("busy_start_done", 64'(seen_done), 1);

    // Reset in the middle of a run drops the pending result
    @(negedge clk);
    result_ready = 1'b0;
    do_start(2, 4);
    wait_valid("midrst");
    reset_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_en = 1'b1;
    chk("midrst_valid", 64'(result_valid), 0);
    chk("midrst_busy", 64'(busy), 0);
    chk("midrst_read_index", 64'(read_index), 0);
    chk("midrst_result", result, 0);
    @(negedge clk);
    chk("midrst_idle_valid", 64'(result_valid), 0);
    chk("midrst_idle_done", 64'(done), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
